// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, scan FSM encoding and frame classification helper for the
// 4x4 keypad scanner.
//   NUM_ROWS/NUM_COLS   matrix geometry
//   ROW_TEAM/ROW_POINTS rows the score counter interprets (team select, points)
//   COL_YELLOW/COL_RED  team-select columns on ROW_TEAM
//   scan_state_e        row FSM encoding
//   onehot_count()      classifies a 16-key frame as none / single / multi
package keypad_pkg;

   localparam int unsigned NUM_ROWS   = 4;
   localparam int unsigned NUM_COLS   = 4;
   localparam int unsigned NUM_KEYS   = NUM_ROWS * NUM_COLS;
   localparam int unsigned ROW_TEAM   = 3;
   localparam int unsigned ROW_POINTS = 0;
   localparam int unsigned COL_YELLOW = 0;
   localparam int unsigned COL_RED    = 2;

   typedef enum logic {
      StDrive = 1'b0,
      StEval  = 1'b1
   } scan_state_e;

   typedef enum logic [1:0] {
      OcNone   = 2'd0,
      OcSingle = 2'd1,
      OcMulti  = 2'd2
   } onehot_cnt_e;

   // Counts set bits only as far as "more than one".
   function automatic onehot_cnt_e onehot_count(input logic [NUM_KEYS-1:0] v);
      logic seen;
      logic multi;
      seen  = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
         if (v[i]) begin
            if (seen) multi = 1'b1;
            seen = 1'b1;
         end
      end
      if (multi)     return OcMulti;
      else if (seen) return OcSingle;
      else           return OcNone;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: width-parameterised two-flop synchroniser for asynchronous level inputs.
//   clk_in  destination clock
//   rst     synchronous active-high reset; both stages reset to all-ones (idle pull-up level)
//   d_i     asynchronous input
//   q_o     synchronised output, two cycles of latency
module sync_2ff #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage1_q;
   logic [WIDTH-1:0] stage2_q;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         stage1_q <= '1;
         stage2_q <= '1;
      end else begin
         stage1_q <= d_i;
         stage2_q <= stage1_q;
      end
   end

   assign q_o = stage2_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one row at a time, captures a full
// 16-key frame, and publishes a debounced single key as one-hot row/column levels.
//   clk_in      system clock
//   rst         synchronous active-high reset
//   pad_row_n   row drive, active-low, exactly one bit low
//   pad_col_n   column returns, active-low, asynchronous
//   key_row     one-hot row of the published key (0 = no key)
//   key_column  one-hot column of the published key (0 = no key)
//   key_event   one-cycle pulse when a new non-zero key is published
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned ROW_DWELL = 50000,
   parameter int unsigned SETTLE    = 16,
   parameter int unsigned DEBOUNCE  = 4
) (
   input  logic       clk_in,
   input  logic       rst,
   output logic [3:0] pad_row_n,
   input  logic [3:0] pad_col_n,
   output logic [3:0] key_row,
   output logic [3:0] key_column,
   output logic       key_event
);

   localparam int unsigned CntW = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
   localparam logic [CntW-1:0] CntSettle = CntW'(SETTLE);
   localparam logic [CntW-1:0] CntLast   = CntW'(ROW_DWELL - 1);
   localparam logic [3:0]      DebMax    = 4'(DEBOUNCE);

   logic [3:0]          sync_col_n;
   logic [3:0]          col;

   scan_state_e         state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [1:0]          row_q, row_d;
   logic [3:0]          row_n_q, row_n_d;
   logic [NUM_KEYS-1:0] frame_q, frame_d;
   logic [NUM_KEYS-1:0] cand_q, cand_d;
   logic [3:0]          deb_q, deb_d;
   logic [NUM_KEYS-1:0] pub_q, pub_d;
   logic                event_q, event_d;
   onehot_cnt_e         frame_cls;

   sync_2ff #(
      .WIDTH (4)
   ) u_col_sync (
      .clk_in (clk_in),
      .rst    (rst),
      .d_i    (pad_col_n),
      .q_o    (sync_col_n)
   );

   assign col = ~sync_col_n;

   // Row FSM, frame capture and debounce. EVAL shares its cycle with row 0 count 0, so the
   // dwell counter free-runs and the scan period stays exactly 4*ROW_DWELL.
   always_comb begin
      state_d   = StDrive;
      cnt_d     = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
      row_d     = row_q;
      row_n_d   = row_n_q;
      frame_d   = frame_q;
      cand_d    = cand_q;
      deb_d     = deb_q;
      pub_d     = pub_q;
      event_d   = 1'b0;
      frame_cls = onehot_count(frame_q);

      if (cnt_q == CntSettle) begin
         frame_d[{row_q, 2'b00} +: 4] = col;
      end

      if (cnt_q == CntLast) begin
         row_d   = row_q + 2'd1;
         row_n_d = {row_n_q[2:0], row_n_q[3]};
         if (row_q == 2'd3) state_d = StEval;
      end

      case (state_q)
         StEval: begin
            // Ghosted frames neither advance nor break a run.
            if (frame_cls != OcMulti) begin
               if (frame_q == cand_q) begin
                  if (deb_q < DebMax) deb_d = deb_q + 4'd1;
               end else begin
                  cand_d = frame_q;
                  deb_d  = 4'd1;
               end
               if ((deb_d == DebMax) && (cand_d != pub_q)) begin
                  pub_d   = cand_d;
                  event_d = (cand_d != '0);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q <= StDrive;
         cnt_q   <= '0;
         row_q   <= 2'd0;
         row_n_q <= 4'b1110;
         frame_q <= '0;
         cand_q  <= '0;
         deb_q   <= 4'd0;
         pub_q   <= '0;
         event_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         row_n_q <= row_n_d;
         frame_q <= frame_d;
         cand_q  <= cand_d;
         deb_q   <= deb_d;
         pub_q   <= pub_d;
         event_q <= event_d;
      end
   end

   // pub_q only ever holds zero or a single key, so OR-reducing gives clean one-hot outputs.
   always_comb begin
      key_row    = '0;
      key_column = '0;
      for (int r = 0; r < int'(NUM_ROWS); r++) begin
         for (int c = 0; c < int'(NUM_COLS); c++) begin
            if (pub_q[r*NUM_COLS + c]) begin
               key_row[r]    = 1'b1;
               key_column[c] = 1'b1;
            end
         end
      end
   end

   assign pad_row_n = row_n_q;
   assign key_event = event_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with ROW_DWELL=8, SETTLE=3, DEBOUNCE=3.
// Cycle t=0 is the first cycle after reset with row 0 at dwell count 0; a frame spans 32
// cycles, EVAL of frame k falls on t=32(k+1) and published outputs appear one cycle later.
// Key presses change at t=32k+1 so each frame samples a single press pattern.
module tb_keypad_scanner;

   logic        clk_in = 1'b0;
   logic        rst    = 1'b1;
   logic [3:0]  pad_row_n;
   logic [3:0]  pad_col_n;
   logic [3:0]  key_row;
   logic [3:0]  key_column;
   logic        key_event;
   logic [15:0] press = '0;

   int t      = 0;
   int ev_cnt = 0;
   int n_cmp  = 0;
   int n_err  = 0;

   always #5 clk_in = ~clk_in;

   // Keypad model: a pressed key pulls its column low only while its row is driven low.
   always_comb begin
      pad_col_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (press[r*4 + c] && !pad_row_n[r]) pad_col_n[c] = 1'b0;
         end
      end
   end

   keypad_scanner #(
      .ROW_DWELL (8),
      .SETTLE    (3),
      .DEBOUNCE  (3)
   ) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .pad_row_n  (pad_row_n),
      .pad_col_n  (pad_col_n),
      .key_row    (key_row),
      .key_column (key_column),
      .key_event  (key_event)
   );

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
      end
   endtask

   task automatic check_keys(input string tag, input logic [3:0] r, input logic [3:0] c,
                             input logic e);
      check_eq({tag, ".row"}, 16'(key_row), 16'(r));
      check_eq({tag, ".col"}, 16'(key_column), 16'(c));
      check_eq({tag, ".evt"}, 16'(key_event), 16'(e));
   endtask

   // Advance to the negedge of cycle target; counts key_event pulses seen on the way.
   task automatic goto(input int target);
      while (t < target) begin
         @(negedge clk_in);
         t++;
         if (key_event) ev_cnt++;
      end
   endtask

   int          ts[7]   = '{0, 7, 8, 16, 24, 31, 32};
   logic [3:0]  rows[7] = '{4'b1110, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0111, 4'b1110};

   initial begin
      // Reset state
      repeat (3) @(negedge clk_in);
      check_eq("rst.pad_row_n", 16'(pad_row_n), 16'h000E);
      check_keys("rst", 4'b0000, 4'b0000, 1'b0);
      rst = 1'b0;
      t   = 0;

      // 1: idle scan, row rotation every 8 cycles
      for (int i = 0; i < 7; i++) begin
         goto(ts[i]);
         check_eq("scan.pad_row_n", 16'(pad_row_n), 16'(rows[i]));
      end
      check_keys("idle", 4'b0000, 4'b0000, 1'b0);
      check_eq("idle.ev_cnt", 16'(ev_cnt), 16'd0);

      // 2: row3/col0 held from frame 1, published after EVAL at 128
      goto(33);
      press = 16'h1000;
      goto(128);
      check_keys("r3c0.pre", 4'b0000, 4'b0000, 1'b0);
      goto(129);
      check_keys("r3c0.pub", 4'b1000, 4'b0001, 1'b1);
      press = 16'h0002;  // direct change to row0/col1 from frame 4
      goto(130);
      check_eq("r3c0.evt_end", 16'(key_event), 16'd0);
      check_eq("r3c0.ev_cnt", 16'(ev_cnt), 16'd1);
      goto(224);
      check_keys("r0c1.pre", 4'b1000, 4'b0001, 1'b0);
      goto(225);
      check_keys("r0c1.pub", 4'b0001, 4'b0010, 1'b1);
      goto(226);
      check_eq("r0c1.ev_cnt", 16'(ev_cnt), 16'd2);

      // 5: release from frame 8, outputs clear after EVAL at 352 with no event
      goto(257);
      press = 16'h0000;
      goto(352);
      check_keys("rel.pre", 4'b0001, 4'b0010, 1'b0);
      goto(353);
      check_keys("rel.clr", 4'b0000, 4'b0000, 1'b0);
      check_eq("rel.ev_cnt", 16'(ev_cnt), 16'd2);

      // 3: press toggling every frame, frames 11..16
      for (int i = 0; i < 6; i++) begin
         goto(32*(11 + i) + 1);
         check_keys("toggle", 4'b0000, 4'b0000, 1'b0);
         press = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      end
      goto(545);
      check_keys("toggle.end", 4'b0000, 4'b0000, 1'b0);
      check_eq("toggle.ev_cnt", 16'(ev_cnt), 16'd2);

      // 4: row0/col0 published, then ghosted two-key frames, then back to one key
      press = 16'h0001;
      goto(640);
      check_keys("r0c0.pre", 4'b0000, 4'b0000, 1'b0);
      goto(641);
      check_keys("r0c0.pub", 4'b0001, 4'b0001, 1'b1);
      press = 16'h0003;
      goto(673);
      check_keys("multi.1", 4'b0001, 4'b0001, 1'b0);
      goto(705);
      check_keys("multi.2", 4'b0001, 4'b0001, 1'b0);
      press = 16'h0001;
      goto(737);
      check_keys("multi.drop", 4'b0001, 4'b0001, 1'b0);
      goto(769);
      check_keys("multi.hold", 4'b0001, 4'b0001, 1'b0);
      check_eq("multi.ev_cnt", 16'(ev_cnt), 16'd3);

      // 6: one-cycle reset in the middle of row 2 with the key still held
      goto(787);
      rst = 1'b1;
      goto(788);
      check_eq("mid_rst.pad_row_n", 16'(pad_row_n), 16'h000E);
      check_keys("mid_rst", 4'b0000, 4'b0000, 1'b0);
      rst = 1'b0;
      goto(796);
      check_eq("mid_rst.row1", 16'(pad_row_n), 16'h000D);
      goto(884);
      check_keys("repub.pre", 4'b0000, 4'b0000, 1'b0);
      goto(885);
      check_keys("repub.pub", 4'b0001, 4'b0001, 1'b1);
      goto(886);
      check_eq("repub.evt_end", 16'(key_event), 16'd0);
      check_eq("repub.ev_cnt", 16'(ev_cnt), 16'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
